// File: rtl/adder_pkg.sv
// Shared opcode encoding and pipeline constants for the pipelined add/sub/accumulate unit.
package adder_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ACC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  localparam int PIPE_LATENCY = 2;

endpackage

// File: rtl/adder_alu.sv
// Combinational datapath: computes the stage-2 result, overflow flag and next accumulator value.
module adder_alu
  import adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic [ACC_WIDTH-1:0] acc,
  output logic [ACC_WIDTH-1:0] next_result,
  output logic [ACC_WIDTH-1:0] next_acc,
  output logic                 next_ovf
);

  if (ACC_WIDTH < WIDTH + 1) begin : g_bad_width
    $error("adder_alu: ACC_WIDTH must be at least WIDTH+1");
  end

  localparam int PAD = ACC_WIDTH - WIDTH;

  logic [ACC_WIDTH-1:0] a_ext;
  logic [ACC_WIDTH-1:0] b_ext;
  logic [ACC_WIDTH-1:0] diff;
  logic [ACC_WIDTH:0]   sum;

  assign a_ext = {{PAD{1'b0}}, a};
  assign b_ext = {{PAD{1'b0}}, b};
  assign diff  = a_ext - b_ext;
  // One spare bit so the carry out of acc + a + b is visible as the overflow.
  assign sum   = {1'b0, acc} + {1'b0, a_ext} + {1'b0, b_ext};

  always_comb begin
    next_result = '0;
    next_acc    = acc;
    next_ovf    = 1'b0;
    case (op_e'(op))
      OP_ADD: next_result = a_ext + b_ext;
      OP_SUB: begin
        next_result = diff;
        if (a < b) begin
          next_ovf = 1'b1;
          if (SATURATE != 0) next_result = '0;
        end
      end
      OP_ACC: begin
        next_acc = sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH]) begin
          next_ovf = 1'b1;
          if (SATURATE != 0) next_acc = '1;
        end
        next_result = next_acc;
      end
      OP_CLR: next_acc = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/adder_pipe.sv
// Two-stage valid/ready add/sub/accumulate pipeline; the accumulator commits only when stage 1 advances.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 ovf
);

  localparam int STAGES = 2;
  if (STAGES != PIPE_LATENCY) begin : g_bad_latency
    $error("adder_pipe: stage count disagrees with PIPE_LATENCY");
  end

  logic                 s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;

  logic                 s2_free, s1_adv, accept;
  logic [ACC_WIDTH-1:0] alu_result, alu_acc;
  logic                 alu_ovf;

  adder_alu #(
    .WIDTH    (WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .SATURATE (SATURATE)
  ) u_alu (
    .a          (a_q),
    .b          (b_q),
    .op         (op_q),
    .acc        (acc_q),
    .next_result(alu_result),
    .next_acc   (alu_acc),
    .next_ovf   (alu_ovf)
  );

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      a_d        = a;
      b_d        = b;
      op_d       = op;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // A new beat advancing overrides the drain, so out_valid never bubbles under full throughput.
    if (s1_adv) begin
      out_valid_d = 1'b1;
      result_d    = alu_result;
      ovf_d       = alu_ovf;
      acc_d       = alu_acc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: a saturating and a wrapping instance run on identical stimulus.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W  = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [1:0]    op;
  logic          in_ready, out_valid, ovf;
  logic [AW-1:0] result;
  logic          in_ready_w, out_valid_w, ovf_w;
  logic [AW-1:0] result_w;

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
    .result(result_w), .ovf(ovf_w)
  );

  typedef struct packed {
    logic [AW-1:0] res_s;
    logic          ovf_s;
    logic [AW-1:0] res_w;
    logic          ovf_w;
  } exp_t;

  exp_t          sb[$];
  int            checks   = 0;
  int            failures = 0;
  int            accepts  = 0;
  int            pops     = 0;
  logic [AW-1:0] acc_s = '0, acc_w = '0;
  logic [AW-1:0] last_res_s = '0, last_res_w = '0;
  logic          last_ovf_s = 1'b0, last_ovf_w = 1'b0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_res = '0;
  logic          prev_ovf = 1'b0;

  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                input bit sat, inout logic [AW-1:0] acc,
                                output logic [AW-1:0] res, output logic ov);
    int xi, yi, s;
    xi  = int'(x);
    yi  = int'(y);
    res = '0;
    ov  = 1'b0;
    case (o)
      2'b00: res = AW'(xi + yi);
      2'b01: begin
        if (xi >= yi) res = AW'(xi - yi);
        else begin
          ov  = 1'b1;
          res = sat ? '0 : AW'(xi - yi + (1 << AW));
        end
      end
      2'b10: begin
        s = int'(acc) + xi + yi;
        if (s > (1 << AW) - 1) begin
          ov  = 1'b1;
          acc = sat ? '1 : AW'(s - (1 << AW));
        end else begin
          acc = AW'(s);
        end
        res = acc;
      end
      default: begin
        acc = '0;
        res = '0;
      end
    endcase
  endfunction

  // One clock: compare outputs and track accepts at the falling edge, then return just after the rising edge.
  task automatic tick();
    exp_t          e;
    logic [AW-1:0] rs, rw;
    logic          os, ow;
    @(negedge clk);
    checks++;
    if (out_valid_w !== out_valid || in_ready_w !== in_ready) begin
      failures++;
      $display("FAIL handshake_match sat=%b/%b wrap=%b/%b (out_valid/in_ready must agree)",
               out_valid, in_ready, out_valid_w, in_ready_w);
    end
    if (prev_stall) begin
      checks++;
      if (out_valid !== 1'b1 || result !== prev_res || ovf !== prev_ovf) begin
        failures++;
        $display("FAIL hold got v=%b r=%0d o=%b expected v=1 r=%0d o=%b",
                 out_valid, result, ovf, prev_res, prev_ovf);
      end
    end
    if (out_valid && out_ready) begin
      checks++;
      pops++;
      last_res_s = result;
      last_ovf_s = ovf;
      last_res_w = result_w;
      last_ovf_w = ovf_w;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_empty got result=%0d with no beat expected", result);
      end else begin
        e = sb.pop_front();
        if (result !== e.res_s || ovf !== e.ovf_s || result_w !== e.res_w || ovf_w !== e.ovf_w) begin
          failures++;
          $display("FAIL result got sat=%0d/%b wrap=%0d/%b expected sat=%0d/%b wrap=%0d/%b",
                   result, ovf, result_w, ovf_w, e.res_s, e.ovf_s, e.res_w, e.ovf_w);
        end
      end
    end
    if (in_valid && in_ready) begin
      model(op, a, b, 1'b1, acc_s, rs, os);
      model(op, a, b, 1'b0, acc_w, rw, ow);
      e = '{res_s: rs, ovf_s: os, res_w: rw, ovf_w: ow};
      sb.push_back(e);
      accepts++;
    end
    prev_stall = out_valid && !out_ready;
    prev_res   = result;
    prev_ovf   = ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 * PIPE_LATENCY && (sb.size() != 0 || out_valid); i++) tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain got pending=%0d out_valid=%b expected 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = OP_ADD;
    #12;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0 || result_w !== '0 || out_valid_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got v=%b r=%0d o=%b rw=%0d expected 0/0/0/0", out_valid, result, ovf, result_w);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add();
    int va[3] = '{15, 0, 1};
    int vb[3] = '{15, 0, 2};
    int vr[3] = '{30, 0, 3};
    for (int i = 0; i < 3; i++) begin
      op        = OP_ADD;
      a         = W'(va[i]);
      b         = W'(vb[i]);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL add_latency_early got out_valid=%b expected 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== AW'(vr[i]) || ovf !== 1'b0) begin
        failures++;
        $display("FAIL add got v=%b r=%0d o=%b expected 1/%0d/0", out_valid, result, ovf, vr[i]);
      end
      drain();
    end
  endtask

  task automatic test_sub();
    int va[5]  = '{3, 9, 15, 0, 7};
    int vb[5]  = '{5, 4, 0, 1, 7};
    int rs[5]  = '{0, 5, 15, 0, 0};
    int rw[5]  = '{254, 5, 15, 255, 0};
    int ov[5]  = '{1, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      op        = OP_SUB;
      a         = W'(va[i]);
      b         = W'(vb[i]);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || result !== AW'(rs[i]) || ovf !== ov[i][0] ||
          result_w !== AW'(rw[i]) || ovf_w !== ov[i][0]) begin
        failures++;
        $display("FAIL sub %0d-%0d got sat=%0d/%b wrap=%0d/%b expected sat=%0d/%0d wrap=%0d/%0d",
                 va[i], vb[i], result, ovf, result_w, ovf_w, rs[i], ov[i], rw[i], ov[i]);
      end
      drain();
    end
  endtask

  task automatic test_acc();
    int n0;
    out_ready = 1'b1;
    op        = OP_CLR;
    a         = '0;
    b         = '0;
    in_valid  = 1'b1;
    n0        = accepts;
    tick();
    op = OP_ACC;
    a  = 4'hF;
    b  = 4'hF;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (accepts - n0 != 10) begin
      failures++;
      $display("FAIL acc_no_bubble got accepted=%0d expected 10", accepts - n0);
    end
    drain();
    checks++;
    if (last_res_s !== 8'd255 || last_ovf_s !== 1'b1 || last_res_w !== 8'd14 || last_ovf_w !== 1'b1) begin
      failures++;
      $display("FAIL acc_overflow got sat=%0d/%b wrap=%0d/%b expected sat=255/1 wrap=14/1",
               last_res_s, last_ovf_s, last_res_w, last_ovf_w);
    end
  endtask

  task automatic test_backpressure();
    int n0, p0;
    out_ready = 1'b1;
    op        = OP_CLR;
    in_valid  = 1'b1;
    tick();
    drain();
    op        = OP_ACC;
    a         = 4'd5;
    b         = 4'd3;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    n0        = accepts;
    p0        = pops;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (accepts - n0 != 2 || in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'd8) begin
      failures++;
      $display("FAIL backpressure got accepted=%0d in_ready=%b v=%b r=%0d expected 2/0/1/8",
               accepts - n0, in_ready, out_valid, result);
    end
    drain();
    checks++;
    if (pops - p0 != 2 || last_res_s !== 8'd16) begin
      failures++;
      $display("FAIL backpressure_drain got beats=%0d last=%0d expected 2/16", pops - p0, last_res_s);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = OP_ACC;
    a         = 4'd7;
    b         = 4'd7;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== '0 || ovf !== 1'b0 || out_valid_w !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got v=%b r=%0d o=%b expected 0/0/0", out_valid, result, ovf);
    end
    sb.delete();
    acc_s      = '0;
    acc_w      = '0;
    prev_stall = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_spurious got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    op       = OP_ACC;
    a        = 4'd1;
    b        = 4'd1;
    in_valid = 1'b1;
    tick();
    drain();
    checks++;
    if (last_res_s !== 8'd2 || last_res_w !== 8'd2) begin
      failures++;
      $display("FAIL reset_mid_acc got sat=%0d wrap=%0d expected 2/2", last_res_s, last_res_w);
    end
  endtask

  task automatic test_random();
    int n0, cyc, r;
    n0  = accepts;
    cyc = 0;
    while (accepts - n0 < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = W'($urandom_range(0, 15));
      b         = W'($urandom_range(0, 15));
      r         = int'($urandom_range(0, 15));
      if (r < 5)       op = OP_ADD;
      else if (r < 9)  op = OP_SUB;
      else if (r < 15) op = OP_ACC;
      else             op = OP_CLR;
      tick();
      cyc++;
    end
    checks++;
    if (accepts - n0 < 10000) begin
      failures++;
      $display("FAIL random_timeout got accepted=%0d expected 10000", accepts - n0);
    end
    drain();
    op       = OP_ACC;
    a        = '0;
    b        = '0;
    in_valid = 1'b1;
    tick();
    drain();
    checks++;
    if (last_res_s !== acc_s || last_res_w !== acc_w) begin
      failures++;
      $display("FAIL random_final_acc got sat=%0d wrap=%0d expected sat=%0d wrap=%0d",
               last_res_s, last_res_w, acc_s, acc_w);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
Parametrised, pipelined unsigned add/subtract/accumulate unit. It has a valid/ready handshake on both input and output, and optional saturation with an overflow flag. It replaces single-cycle, non-handshaked operand adders in datapaths. It sits between an operand producer and a result consumer, and both may stall independently.

Parameters:
WIDTH, 4, operand width of a and b in bits (>= 1).
ACC_WIDTH, 8, result/accumulator width in bits; must be >= WIDTH+1 (checked by elaboration assertion).
SATURATE, 1, 1 = clamp on overflow/underflow, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
clk  input  1  clock, all state rising-edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  operand beat present.
in_ready  output  1  block can accept an operand beat this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
op  input  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
out_valid  output  1  result beat present.
out_ready  input  1  consumer accepts result this cycle.
result  output  ACC_WIDTH  computed value.
ovf  output  1  overflow/underflow flag, qualified by out_valid.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0, accumulator = 0, result = 0, ovf = 0, out_valid = 0. in_ready = 1 from the first cycle after reset.
- Input acceptance: a beat is accepted when in_valid && in_ready. in_ready is combinational: !s1_valid || s1_adv.
- Stage advance rules:
  - s2_free = !out_valid || out_ready.
  - s1_adv = s1_valid && s2_free.
- Stage 1 registers a, b and op on accept.
- Stage 2 computes on s1_adv and registers result and ovf.
- Latency: 2 cycles from accept to out_valid with no stall. Throughput is 1 beat/cycle when out_ready is held high.
- Hold rule: while out_valid && !out_ready, result and ovf must not change.
- Drain rule: out_valid falls after a transfer only if no new beat advances that same cycle.
- ADD:
  - result = zero-extend(a) + zero-extend(b).
  - Cannot overflow; ovf = 0.
- SUB (a - b):
  - If a >= b: exact difference, ovf = 0.
  - If a < b: ovf = 1. result = 0 when SATURATE=1, otherwise (a - b) mod 2^ACC_WIDTH.
- ACC:
  - sum = acc + a + b, computed at ACC_WIDTH+1 bits.
  - If sum > 2^ACC_WIDTH-1: ovf = 1. acc = all-ones when SATURATE=1, otherwise sum mod 2^ACC_WIDTH.
  - result = the new acc value.
- CLR: acc = 0, result = 0, ovf = 0.
- ADD and SUB do not modify acc.
- acc updates only on s1_adv. Back-to-back ACC beats therefore chain correctly with no hazard and no bubble.
- A stalled beat in stage 1 never touches acc until it advances.
- Reset mid-operation: in-flight beats are discarded, acc returns to 0, and no spurious out_valid is produced.

Decomposition:
- Package adder_pkg holds:
  - op_e typedef: OP_ADD=2'b00, OP_SUB=2'b01, OP_ACC=2'b10, OP_CLR=2'b11.
  - Shared localparam for pipeline latency (2).
- One combinational sub-module, adder_alu (parameters WIDTH, ACC_WIDTH, SATURATE):
  - Inputs: a, b, op, acc.
  - Outputs: next_result, next_acc, next_ovf.
- adder_pipe owns the handshake, pipeline registers and accumulator.

Test Plan:
1. Reset: assert reset mid-cycle -> result=0, ovf=0 and out_valid=0 immediately; after release in_ready=1.
2. ADD: a=4'hF, b=4'hF, out_ready=1 -> out_valid two cycles later, result=8'h1E, ovf=0.
3. SUB underflow: a=3, b=5 -> SATURATE=1 gives result=0, ovf=1; SATURATE=0 gives result=8'hFE, ovf=1. Also a=9, b=4 -> result=5, ovf=0.
4. ACC saturation: CLR, then nine back-to-back ACC beats with a=15, b=15 -> results 30, 60, ..., 240 with ovf=0, then 255 with ovf=1 (SATURATE=1), or 14 with ovf=1 (SATURATE=0).
5. Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats accepted, then in_ready=0 and result stable. On out_ready=1 all beats emerge in order with correct ACC chaining and none lost or duplicated.
6. Random valid/ready toggling, 10k beats, against a scoreboard model -> every result and ovf matches; acc equals the reference value after the final beat.
